hazard3_apb_requester: RTL and testbench
========================================

// Module: hazard3_apb_requester
// PURPOSE
//  APB3 requester (initiator): turns a one-outstanding valid/ready request port into APB
//  SETUP/ACCESS transfers, returns read data and error on a held response port.
//  Sits between the SoC bus fabric and APB completers such as hazard3_riscv_timer.
// PARAMETERS
//  W_ADDR          16   paddr / req_addr width
//  W_DATA          32   pwdata / prdata / req_wdata / resp_rdata width
//  TIMEOUT_CYCLES  255  ACCESS cycles without pready before abort (HAZARD3_APB_TIMEOUT_EN only), >=1
// PORTS
//  clk         in   1       clock; all logic rising-edge
//  rst         in   1       synchronous, active-high reset
//  req_valid   in   1       request present
//  req_ready   out  1       request accepted when req_valid && req_ready
//  req_write   in   1       1 = write, 0 = read
//  req_addr    in   W_ADDR  byte address
//  req_wdata   in   W_DATA  write data
//  resp_valid  out  1       response present; held until resp_ready
//  resp_ready  in   1       response consumed when resp_valid && resp_ready
//  resp_rdata  out  W_DATA  read data (0 for writes, errors, timeouts)
//  resp_err    out  1       pslverr seen, or timeout
//  resp_timeout out 1       transfer aborted by timeout (constant 0 without macro)
//  paddr       out  W_ADDR  APB address
//  psel        out  1       APB select
//  penable     out  1       APB enable
//  pwrite      out  1       APB direction
//  pwdata      out  W_DATA  APB write data
//  prdata      in   W_DATA  APB read data
//  pready      in   1       APB ready
//  pslverr     in   1       APB error
// BEHAVIOUR
//  - Reset (rst=1 at edge): state IDLE; psel, penable, pwrite, resp_valid, resp_err, resp_timeout = 0;
//    paddr, pwdata, resp_rdata = 0. Mid-transfer reset drops the transfer; no response is produced.
//  - All APB outputs and resp_* are registered. req_ready is combinational:
//    req_ready = (state==IDLE) && !resp_valid. One transfer outstanding, no pipelining.
//  - FSM: IDLE -> SETUP on accept; SETUP -> ACCESS unconditionally; ACCESS -> IDLE on pready
//    (or on timeout). IDLE only when not in a transfer.
//  - Timing: accept at edge N -> psel=1,penable=0 in cycle N+1 -> psel=1,penable=1 from N+2;
//    first cycle with pready=1 in ACCESS (cycle M) completes; cycle M+1: psel=penable=0,
//    resp_valid=1. Zero-wait transfer: 3 cycles accept-to-response.
//  - paddr/pwrite/pwdata captured at accept, stable from SETUP to completion; pwdata=0 on reads.
//  - Completion capture: resp_err=pslverr; resp_rdata = (read && !pslverr) ? prdata : 0.
//  - pready/pslverr/prdata ignored outside ACCESS.
//  - Response held unchanged while resp_valid && !resp_ready; cleared the edge after handshake.
//    Next request is accepted no earlier than the cycle after resp_valid drops.
// CONFIGURATION
//  HAZARD3_APB_TIMEOUT_EN defined: counter cleared on entry to ACCESS, increments each ACCESS
//   cycle with pready=0; when it equals TIMEOUT_CYCLES (and pready=0) the transfer aborts: next
//   cycle psel=penable=0, resp_valid=1, resp_err=1, resp_timeout=1, resp_rdata=0. pready on
//   the abort cycle wins (normal completion). Counter width $clog2(TIMEOUT_CYCLES+1).
//  Not defined: no counter; ACCESS waits indefinitely; resp_timeout tied 0.
// STRUCTURE
//  - Package hazard3_apb_pkg: state encoding (APB_IDLE/APB_SETUP/APB_ACCESS, 2 bits),
//    default TIMEOUT_CYCLES constant; shared with future APB completers/monitors.
//  - Sub-module hazard3_apb_timeout_ctr (clear, count-enable, expired output), instanced only
//    under HAZARD3_APB_TIMEOUT_EN. Everything else flat in this module.
// TESTING
//  1 Write 0x0008 <- 0x12345678, pready=1 always, resp_ready=1 -> psel N+1, penable N+2,
//    paddr=0x0008 pwdata=0x12345678 pwrite=1; resp_valid N+3, resp_err=0, resp_rdata=0.
//  2 Read 0x000c, pready low 3 ACCESS cycles, prdata=0xdeadbeef on pready -> penable high 4
//    cycles, paddr stable throughout, resp_rdata=0xdeadbeef, resp_err=0.
//  3 Read 0x0010 with pslverr=1 at completion, prdata=0xffffffff -> resp_err=1, resp_rdata=0.
//  4 resp_ready=0 for 5 cycles after response, req_valid held high -> req_ready=0, resp stable,
//    psel=0; second request accepted only the cycle after resp handshake.
//  5 (macro, TIMEOUT_CYCLES=8) pready stuck 0 -> 8 ACCESS cycles with pready=0 then psel=0,
//    resp_err=1, resp_timeout=1; without macro psel stays high for 1000 cycles.
//  6 rst=1 for 1 cycle during ACCESS -> next cycle psel=penable=resp_valid=0, req_ready=1; new
//    request then runs normally.

Source files
------------

// File: rtl/hazard3_apb_pkg.sv
// Shared APB definitions: requester FSM state encoding and default abort threshold.
// Used by hazard3_apb_requester and intended for future APB completers/monitors.
package hazard3_apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/hazard3_apb_timeout_ctr.sv
// Counts ACCESS cycles without pready; expired flags the cycle that reaches the threshold.
// Only instanced when HAZARD3_APB_TIMEOUT_EN is defined.
module hazard3_apb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current stalled cycle is the TIMEOUT_CYCLES-th one, so abort on it.
  assign expired = count_en && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hazard3_apb_requester.sv
// APB3 requester: one-outstanding valid/ready request port to SETUP/ACCESS transfers.
// Optional ACCESS-phase abort enabled by defining HAZARD3_APB_TIMEOUT_EN.
module hazard3_apb_requester
  import hazard3_apb_pkg::*;
#(
  parameter int unsigned W_ADDR         = 16,
  parameter int unsigned W_DATA         = 32,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [W_ADDR-1:0] req_addr,
  input  logic [W_DATA-1:0] req_wdata,

  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W_DATA-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_timeout,

  output logic [W_ADDR-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [W_DATA-1:0] pwdata,
  input  logic [W_DATA-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        state_q, state_d;
  logic [W_ADDR-1:0] paddr_q, paddr_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [W_DATA-1:0] pwdata_q, pwdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [W_DATA-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              resp_timeout_q, resp_timeout_d;

  logic              timeout_expired;

`ifdef HAZARD3_APB_TIMEOUT_EN
  logic ctr_clear;
  logic ctr_count_en;

  assign ctr_clear    = (state_q == APB_SETUP);
  assign ctr_count_en = (state_q == APB_ACCESS) && !pready;

  hazard3_apb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .count_en(ctr_count_en),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  assign req_ready = (state_q == APB_IDLE) && !resp_valid_q;

  always_comb begin
    state_d        = state_q;
    paddr_d        = paddr_q;
    psel_d         = psel_q;
    penable_d      = penable_q;
    pwrite_d       = pwrite_q;
    pwdata_d       = pwdata_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;
    resp_timeout_d = resp_timeout_q;

    if (resp_valid_q && resp_ready) begin
      resp_valid_d   = 1'b0;
      resp_rdata_d   = '0;
      resp_err_d     = 1'b0;
      resp_timeout_d = 1'b0;
    end

    unique case (state_q)
      APB_IDLE: begin
        if (req_valid && req_ready) begin
          state_d   = APB_SETUP;
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          pwdata_d  = req_write ? req_wdata : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      APB_SETUP: begin
        state_d   = APB_ACCESS;
        penable_d = 1'b1;
      end
      APB_ACCESS: begin
        // pready wins over a same-cycle timeout
        if (pready) begin
          state_d        = APB_IDLE;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          resp_valid_d   = 1'b1;
          resp_err_d     = pslverr;
          resp_timeout_d = 1'b0;
          resp_rdata_d   = (!pwrite_q && !pslverr) ? prdata : '0;
        end else if (timeout_expired) begin
          state_d        = APB_IDLE;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          resp_valid_d   = 1'b1;
          resp_err_d     = 1'b1;
          resp_timeout_d = 1'b1;
          resp_rdata_d   = '0;
        end
      end
      default: begin
        state_d   = APB_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= APB_IDLE;
      paddr_q        <= '0;
      psel_q         <= 1'b0;
      penable_q      <= 1'b0;
      pwrite_q       <= 1'b0;
      pwdata_q       <= '0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      paddr_q        <= paddr_d;
      psel_q         <= psel_d;
      penable_q      <= penable_d;
      pwrite_q       <= pwrite_d;
      pwdata_q       <= pwdata_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign paddr        = paddr_q;
  assign psel         = psel_q;
  assign penable      = penable_q;
  assign pwrite       = pwrite_q;
  assign pwdata       = pwdata_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_hazard3_apb_requester.sv
// Directed bench for hazard3_apb_requester: table of single transfers plus hand-written
// sequences for response backpressure, ACCESS stall/timeout and mid-transfer reset.
module tb_hazard3_apb_requester;

  localparam int unsigned W_ADDR  = 16;
  localparam int unsigned W_DATA  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [W_ADDR-1:0] req_addr;
  logic [W_DATA-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [W_DATA-1:0] resp_rdata;
  logic              resp_err;
  logic              resp_timeout;
  logic [W_ADDR-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [W_DATA-1:0] pwdata;
  logic [W_DATA-1:0] prdata;
  logic              pready;
  logic              pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard3_apb_requester #(
    .W_ADDR        (W_ADDR),
    .W_DATA        (W_DATA),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .resp_timeout(resp_timeout),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  typedef struct {
    logic              write;
    logic [W_ADDR-1:0] addr;
    logic [W_DATA-1:0] wdata;
    int unsigned       waits;
    logic [W_DATA-1:0] prdata;
    logic              slverr;
    logic [W_DATA-1:0] exp_rdata;
    logic              exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer from an idle DUT, cycle-accurate checks throughout.
  task automatic do_xfer(input vec_t v);
    int pen_cycles;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_write  = v.write;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    req_wdata = '0;
    check("setup_psel_penable", {30'd0, psel, penable}, 32'd2);
    check("setup_paddr", {16'd0, paddr}, {16'd0, v.addr});
    check("setup_pwrite", {31'd0, pwrite}, {31'd0, v.write});
    check("setup_pwdata", pwdata, v.write ? v.wdata : 32'd0);
    check("setup_req_ready", {31'd0, req_ready}, 32'd0);
    // Completer signals in SETUP must be ignored
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'hbad0bad0;
    tick();
    pen_cycles = 0;
    for (int w = 0; w <= int'(v.waits); w++) begin
      check("access_psel_penable", {30'd0, psel, penable}, 32'd3);
      check("access_paddr", {16'd0, paddr}, {16'd0, v.addr});
      if (penable) pen_cycles++;
      pready  = (w == int'(v.waits));
      pslverr = (w == int'(v.waits)) ? v.slverr : 1'b0;
      prdata  = (w == int'(v.waits)) ? v.prdata : 32'hbad1bad1;
      tick();
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'h0;
    check("penable_cycles", pen_cycles, v.waits + 1);
    check("done_psel_penable", {30'd0, psel, penable}, 32'd0);
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_rdata", resp_rdata, v.exp_rdata);
    check("resp_err", {31'd0, resp_err}, {31'd0, v.exp_err});
    check("resp_timeout", {31'd0, resp_timeout}, 32'd0);
    check("resp_req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check("resp_cleared", {31'd0, resp_valid}, 32'd0);
    check("req_ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cycles;

    vecs[0] = '{1'b1, 16'h0008, 32'h12345678, 0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 16'h000c, 32'h0, 3, 32'hdeadbeef, 1'b0, 32'hdeadbeef, 1'b0};
    vecs[2] = '{1'b0, 16'h0010, 32'h0, 0, 32'hffffffff, 1'b1, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 16'h0014, 32'ha5a5a5a5, 2, 32'h11111111, 1'b1, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 16'hfffc, 32'h77777777, 1, 32'h0badf00d, 1'b0, 32'h0badf00d, 1'b0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    prdata     = '0;
    pready     = 1'b0;
    pslverr    = 1'b0;
    tick();
    tick();
    check("rst_psel", {31'd0, psel}, 32'd0);
    check("rst_penable", {31'd0, penable}, 32'd0);
    check("rst_pwrite", {31'd0, pwrite}, 32'd0);
    check("rst_resp", {29'd0, resp_valid, resp_err, resp_timeout}, 32'd0);
    check("rst_paddr", {16'd0, paddr}, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 5; i++) do_xfer(vecs[i]);

    // Response backpressure with a second request waiting
    resp_ready = 1'b0;
    pready     = 1'b1;
    prdata     = 32'h01020304;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 16'h0020;
    tick();
    req_write = 1'b1;
    req_addr  = 16'h0024;
    req_wdata = 32'h00000055;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_resp_rdata", resp_rdata, 32'h01020304);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_psel", {31'd0, psel}, 32'd0);
      prdata = 32'hcafe0000 + i;
      tick();
    end
    resp_ready = 1'b1;
    check("bp_hs_req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check("bp_after_valid", {31'd0, resp_valid}, 32'd0);
    check("bp_after_req_ready", {31'd0, req_ready}, 32'd1);
    check("bp_after_psel", {31'd0, psel}, 32'd0);
    tick();
    req_valid = 1'b0;
    check("bp2_psel", {31'd0, psel}, 32'd1);
    check("bp2_paddr", {16'd0, paddr}, 32'h0024);
    check("bp2_pwrite", {31'd0, pwrite}, 32'd1);
    check("bp2_pwdata", pwdata, 32'h00000055);
    tick();
    tick();
    check("bp2_resp", {30'd0, resp_valid, resp_err}, 32'd2);
    check("bp2_rdata", resp_rdata, 32'd0);
    tick();
    pready = 1'b0;

    // ACCESS with pready stuck low
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0030;
    prdata    = 32'h99999999;
    tick();
    req_valid = 1'b0;
    tick();
`ifdef HAZARD3_APB_TIMEOUT_EN
    hi_cycles = 0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      if (psel && penable) hi_cycles++;
      tick();
    end
    check("to_access_cycles", hi_cycles, TIMEOUT);
    check("to_psel_penable", {30'd0, psel, penable}, 32'd0);
    check("to_resp", {29'd0, resp_valid, resp_err, resp_timeout}, 32'd7);
    check("to_rdata", resp_rdata, 32'd0);
    tick();
    check("to_cleared", {31'd0, resp_valid}, 32'd0);
`else
    hi_cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      if (psel && penable && !resp_valid) hi_cycles++;
      tick();
    end
    check("stall_access_cycles", hi_cycles, 1000);
    check("stall_timeout", {30'd0, resp_valid, resp_timeout}, 32'd0);
    pready = 1'b1;
    tick();
    pready = 1'b0;
    check("stall_resp", {30'd0, resp_valid, resp_err}, 32'd2);
    check("stall_rdata", resp_rdata, 32'h99999999);
    tick();
`endif

    // Reset during ACCESS drops the transfer
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0040;
    req_wdata = 32'hfeedface;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("mr_in_access", {30'd0, psel, penable}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_psel_penable", {30'd0, psel, penable}, 32'd0);
    check("mr_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mr_req_ready", {31'd0, req_ready}, 32'd1);
    check("mr_paddr", {16'd0, paddr}, 32'd0);
    tick();
    check("mr_no_resp", {31'd0, resp_valid}, 32'd0);
    do_xfer(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
